// File: rtl/conv_ctrl.sv
// conv_ctrl: sequencing controller for the 1-D convolution engine.
// Loads an M-word x vector and an N-word filter into external memories,
// then drives the MAC accumulator to produce y[i] = sum_j x[i+j]*f[j]
// for i = 0..M-N, one result per output handshake, then returns to LOAD.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   s_valid_x/s_ready_x x input handshake (ready combinational in LOAD)
//   s_valid_f/s_ready_f f input handshake (ready combinational in LOAD)
//   m_valid_y/m_ready_y output handshake (valid registered)
//   wr_en_x, addr_x     x memory write enable / shared read-write address
//   wr_en_f, addr_f     f memory write enable / shared read-write address
//   clear_acc, en_acc   accumulator clear / multiply-accumulate (registered)
module conv_ctrl #(
    parameter int unsigned M = 8,
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid_x,
    output logic                 s_ready_x,
    input  logic                 s_valid_f,
    output logic                 s_ready_f,
    output logic                 m_valid_y,
    input  logic                 m_ready_y,
    output logic                 wr_en_x,
    output logic [$clog2(M)-1:0] addr_x,
    output logic                 wr_en_f,
    output logic [$clog2(N)-1:0] addr_f,
    output logic                 clear_acc,
    output logic                 en_acc
);

    localparam int unsigned AW_X = $clog2(M);
    localparam int unsigned AW_F = $clog2(N);
    localparam int unsigned XCW  = $clog2(M + 1);
    localparam int unsigned FCW  = $clog2(N + 1);
    localparam int unsigned IW   = (M == N) ? 1 : $clog2(M - N + 1);
    localparam int unsigned JW   = AW_F;

    localparam logic [XCW-1:0] X_FULL = XCW'(M);
    localparam logic [FCW-1:0] F_FULL = FCW'(N);
    localparam logic [IW-1:0]  I_LAST = IW'(M - N);
    localparam logic [JW-1:0]  J_LAST = JW'(N - 1);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_OUT     = 2'd3;

    logic [1:0]     r_state;
    logic [XCW-1:0] r_xcnt;
    logic [FCW-1:0] r_fcnt;
    logic [IW-1:0]  r_i;
    logic [JW-1:0]  r_j;
    logic           r_clear_acc;
    logic           r_en_acc;
    logic           r_m_valid_y;

    logic [1:0]     w_state_d;
    logic [XCW-1:0] w_xcnt_d;
    logic [FCW-1:0] w_fcnt_d;
    logic [IW-1:0]  w_i_d;
    logic [JW-1:0]  w_j_d;

    logic w_in_load;
    logic w_x_full;
    logic w_f_full;
    logic w_acc_x;
    logic w_acc_f;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_x_full  = (r_xcnt == X_FULL);
    assign w_f_full  = (r_fcnt == F_FULL);

    // Ready is gated by reset so nothing looks acceptable while held in reset.
    assign s_ready_x = reset & w_in_load & ~w_x_full;
    assign s_ready_f = reset & w_in_load & ~w_f_full;
    assign w_acc_x   = s_valid_x & s_ready_x;
    assign w_acc_f   = s_valid_f & s_ready_f;
    assign wr_en_x   = w_acc_x;
    assign wr_en_f   = w_acc_f;

    always_comb begin
        addr_x = '0;
        addr_f = '0;
        case (r_state)
            ST_LOAD: begin
                addr_x = AW_X'(r_xcnt);
                addr_f = AW_F'(r_fcnt);
            end
            ST_COMPUTE: begin
                // i+j never exceeds M-1, so no wrap in the narrower address.
                addr_x = AW_X'(r_i) + AW_X'(r_j);
                addr_f = AW_F'(r_j);
            end
            default: begin
                addr_x = '0;
                addr_f = '0;
            end
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_xcnt_d  = r_xcnt;
        w_fcnt_d  = r_fcnt;
        w_i_d     = r_i;
        w_j_d     = r_j;
        case (r_state)
            ST_LOAD: begin
                if (w_acc_x) w_xcnt_d = r_xcnt + XCW'(1);
                if (w_acc_f) w_fcnt_d = r_fcnt + FCW'(1);
                if (w_x_full && w_f_full) begin
                    w_state_d = ST_COMPUTE;
                    w_i_d     = '0;
                    w_j_d     = '0;
                end
            end
            ST_COMPUTE: begin
                if (r_j == J_LAST) begin
                    w_state_d = ST_DRAIN;
                    w_j_d     = '0;
                end else begin
                    w_j_d = r_j + JW'(1);
                end
            end
            ST_DRAIN: begin
                w_state_d = ST_OUT;
            end
            ST_OUT: begin
                if (m_ready_y) begin
                    if (r_i == I_LAST) begin
                        w_state_d = ST_LOAD;
                        w_xcnt_d  = '0;
                        w_fcnt_d  = '0;
                    end else begin
                        w_state_d = ST_COMPUTE;
                        w_i_d     = r_i + IW'(1);
                        w_j_d     = '0;
                    end
                end
            end
            default: begin
                w_state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_LOAD;
            r_xcnt      <= '0;
            r_fcnt      <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_clear_acc <= 1'b0;
            r_en_acc    <= 1'b0;
            r_m_valid_y <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_xcnt      <= w_xcnt_d;
            r_fcnt      <= w_fcnt_d;
            r_i         <= w_i_d;
            r_j         <= w_j_d;
            // Registered from next state so the outputs come straight off flops.
            r_clear_acc <= (w_state_d == ST_COMPUTE) && (w_j_d == '0);
            r_m_valid_y <= (w_state_d == ST_OUT);
            // Memory read issued this cycle lands next cycle; MAC follows it.
            r_en_acc    <= (r_state == ST_COMPUTE);
        end
    end

    assign clear_acc = r_clear_acc;
    assign en_acc    = r_en_acc;
    assign m_valid_y = r_m_valid_y;

endmodule

// File: tb/tb_conv_ctrl.sv
module tb_conv_ctrl;
    localparam int M  = 8;
    localparam int N  = 4;
    localparam int NY = M - N + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic s_valid_x = 1'b0, s_valid_f = 1'b0, m_ready_y = 1'b1;
    logic s_ready_x, s_ready_f, m_valid_y, wr_en_x, wr_en_f, clear_acc, en_acc;
    logic [$clog2(M)-1:0] addr_x;
    logic [$clog2(N)-1:0] addr_f;
    logic signed [7:0] x_data = 'x, f_data = 'x;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_ctrl #(.M(M), .N(N)) dut (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
        .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
        .wr_en_x(wr_en_x), .addr_x(addr_x),
        .wr_en_f(wr_en_f), .addr_f(addr_f),
        .clear_acc(clear_acc), .en_acc(en_acc)
    );

    // Datapath model: x/f memories with synchronous read plus MAC accumulator.
    logic smp_wx, smp_wf, smp_vx, smp_vf, smp_clr, smp_en, smp_mv, smp_mr;
    logic [$clog2(M)-1:0] smp_ax;
    logic [$clog2(N)-1:0] smp_af;
    logic signed [7:0] smp_xd, smp_fd;
    logic signed [7:0] x_mem [M];
    logic signed [7:0] f_mem [N];
    logic signed [7:0] x_q, f_q;
    int acc = 0, cyc = 0, en_cnt = 0, viol = 0;
    int got_y[$], got_cyc[$], got_en[$], ce_cyc[$];

    always @(negedge clk) begin
        smp_wx = wr_en_x; smp_wf = wr_en_f; smp_vx = s_valid_x; smp_vf = s_valid_f;
        smp_clr = clear_acc; smp_en = en_acc; smp_mv = m_valid_y; smp_mr = m_ready_y;
        smp_ax = addr_x; smp_af = addr_f; smp_xd = x_data; smp_fd = f_data;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((smp_clr && smp_en) || (smp_wx && (!smp_vx || $isunknown(smp_xd)))
            || (smp_wf && (!smp_vf || $isunknown(smp_fd)))) begin
            viol <= viol + 1;
            $display("monitor: protocol violation at cycle %0d", cyc);
        end
        if (smp_wx) x_mem[smp_ax] <= smp_xd;
        if (smp_wf) f_mem[smp_af] <= smp_fd;
        x_q <= x_mem[smp_ax];
        f_q <= f_mem[smp_af];
        if (smp_clr) begin
            acc <= 0;
            en_cnt <= 0;
            ce_cyc.push_back(cyc);
        end else if (smp_en) begin
            acc <= acc + int'(x_q) * int'(f_q);
            en_cnt <= en_cnt + 1;
        end
        if (smp_mv && smp_mr) begin
            got_y.push_back(acc);
            got_cyc.push_back(cyc);
            got_en.push_back(en_cnt);
        end
    end

    int X1[M] = '{10, -20, 30, -40, 50, 60, 70, 80};
    int F1[N] = '{10, 20, -30, 40};
    int X2[M] = '{-90, 100, -110, 120, -50, 40, 30, -20};
    int F2[N] = '{-50, -60, 70, 80};

    function automatic int conv_y(input int xv[M], input int fv[N], input int i);
        int s = 0;
        for (int j = 0; j < N; j++) s += xv[i + j] * fv[j];
        return s;
    endfunction

    task automatic load_vec(input int xv[M], input int fv[N], input bit gaps,
                            input bit do_x, input bit do_f);
        int xi = 0, fi = 0, guard = 0;
        while (((do_x && xi < M) || (do_f && fi < N)) && guard < 500) begin
            @(posedge clk); #1;
            s_valid_x = do_x && (xi < M) && (!gaps || $urandom_range(0, 2) != 0);
            s_valid_f = do_f && (fi < N) && (!gaps || $urandom_range(0, 2) != 0);
            x_data = s_valid_x ? 8'(xv[xi]) : 'x;
            f_data = s_valid_f ? 8'(fv[fi]) : 'x;
            @(negedge clk);
            if (s_valid_x && s_ready_x) xi++;
            if (s_valid_f && s_ready_f) fi++;
            guard++;
        end
        @(posedge clk); #1;
        s_valid_x = 1'b0; s_valid_f = 1'b0; x_data = 'x; f_data = 'x;
        checks++;
        if (xi != (do_x ? M : 0) || fi != (do_f ? N : 0)) begin
            failures++;
            $display("FAIL load: accepted x=%0d f=%0d", xi, fi);
        end
    endtask

    // mode 0: ready held high; mode 1: random ready.
    task automatic collect(input int n, input int mode);
        int base = got_y.size();
        int guard = 0;
        while (got_y.size() < base + n && guard < 2000) begin
            @(posedge clk); #1;
            m_ready_y = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        m_ready_y = 1'b1;
        checks++;
        if (got_y.size() < base + n) begin
            failures++;
            $display("FAIL collect_timeout: got %0d outputs required %0d",
                     got_y.size() - base, n);
        end
    endtask

    task automatic check_vec(input string name, input int xv[M], input int fv[N],
                             input int yb, input int cb, input bit timing);
        for (int k = 0; k < NY; k++) begin
            checks++;
            if (yb + k >= got_y.size()) begin
                failures++;
                $display("FAIL %s_missing y[%0d]: got none required %0d", name, k,
                         conv_y(xv, fv, k));
            end else begin
                if (got_y[yb + k] !== conv_y(xv, fv, k)) begin
                    failures++;
                    $display("FAIL %s y[%0d]: got %0d required %0d", name, k,
                             got_y[yb + k], conv_y(xv, fv, k));
                end
                checks++;
                if (got_en[yb + k] !== N) begin
                    failures++;
                    $display("FAIL %s en_count[%0d]: got %0d required %0d", name, k,
                             got_en[yb + k], N);
                end
                if (timing && cb + k < ce_cyc.size()) begin
                    checks++;
                    if (got_cyc[yb + k] - ce_cyc[cb + k] !== N + 1) begin
                        failures++;
                        $display("FAIL %s latency[%0d]: got %0d required %0d", name, k,
                                 got_cyc[yb + k] - ce_cyc[cb + k], N + 1);
                    end
                    if (k > 0) begin
                        checks++;
                        if (got_cyc[yb + k] - got_cyc[yb + k - 1] !== N + 2) begin
                            failures++;
                            $display("FAIL %s interval[%0d]: got %0d required %0d", name, k,
                                     got_cyc[yb + k] - got_cyc[yb + k - 1], N + 2);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [13:0] v;
        v = {s_ready_x, s_ready_f, m_valid_y, wr_en_x, wr_en_f, clear_acc, en_acc,
             4'(addr_x), 3'(addr_f)};
        checks++;
        if (v !== 14'd0) begin
            failures++;
            $display("FAIL %s: outputs got %b required all zero", name, v);
        end
    endtask

    task automatic test_reset();
        s_valid_x = 1'b1; s_valid_f = 1'b1; x_data = 8'sd1; f_data = 8'sd1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        s_valid_x = 1'b0; s_valid_f = 1'b0; x_data = 'x; f_data = 'x;
        reset = 1'b1;
        #1;
        checks++;
        if ({s_ready_x, s_ready_f} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_reset: got %b required 11", {s_ready_x, s_ready_f});
        end
    endtask

    task automatic test_basic();
        int yb = got_y.size(), cb = ce_cyc.size();
        load_vec(X1, F1, 1'b0, 1'b1, 1'b1);
        collect(NY, 0);
        check_vec("basic", X1, F1, yb, cb, 1'b1);
    endtask

    task automatic test_back_to_back();
        int yb = got_y.size(), cb = ce_cyc.size(), hi = 0;
        load_vec(X2, F2, 1'b0, 1'b1, 1'b1);
        collect(NY, 0);
        check_vec("b2b", X2, F2, yb, cb, 1'b1);
        repeat (100) begin
            @(negedge clk);
            if (m_valid_y || clear_acc || en_acc) hi++;
        end
        checks++;
        if (hi !== 0) begin
            failures++;
            $display("FAIL idle_quiet: got %0d active cycles required 0", hi);
        end
    endtask

    task automatic test_gaps();
        int yb = got_y.size(), cb = ce_cyc.size();
        load_vec(X1, F1, 1'b1, 1'b1, 1'b1);
        collect(NY, 0);
        check_vec("gaps", X1, F1, yb, cb, 1'b1);
    endtask

    task automatic test_stall();
        int yb = got_y.size(), cb = ce_cyc.size(), guard = 0, bad = 0, n0;
        m_ready_y = 1'b0;
        load_vec(X1, F1, 1'b0, 1'b1, 1'b1);
        while (!m_valid_y && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n0 = got_y.size();
        repeat (20) begin
            @(negedge clk);
            if (!m_valid_y || en_acc || clear_acc) bad++;
        end
        checks++;
        if (bad !== 0 || got_y.size() !== n0) begin
            failures++;
            $display("FAIL stall_hold: got %0d bad cycles, %0d outputs, required 0 and %0d",
                     bad, got_y.size(), n0);
        end
        collect(NY, 0);
        check_vec("stall", X1, F1, yb, cb, 1'b0);
    endtask

    task automatic test_extra_x();
        int yb = got_y.size(), cb = ce_cyc.size(), bad = 0;
        load_vec(X1, F1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        s_valid_x = 1'b1; x_data = 8'sd99;
        repeat (10) begin
            @(negedge clk);
            if (s_ready_x || wr_en_x || clear_acc || m_valid_y) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL extra_x: got %0d cycles with ready/write required 0", bad);
        end
        @(posedge clk); #1;
        s_valid_x = 1'b0; x_data = 'x;
        load_vec(X1, F1, 1'b0, 1'b0, 1'b1);
        collect(NY, 0);
        check_vec("extra_x", X1, F1, yb, cb, 1'b1);
    endtask

    task automatic test_random();
        int xv[M];
        int fv[N];
        for (int r = 0; r < 3; r++) begin
            int yb = got_y.size(), cb = ce_cyc.size();
            for (int k = 0; k < M; k++) xv[k] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < N; k++) fv[k] = int'($urandom_range(0, 255)) - 128;
            load_vec(xv, fv, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            collect(NY, 1);
            check_vec("random", xv, fv, yb, cb, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int yb, cb = ce_cyc.size(), guard = 0;
        m_ready_y = 1'b1;
        load_vec(X1, F1, 1'b0, 1'b1, 1'b1);
        while (ce_cyc.size() < cb + 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (ce_cyc.size() < cb + 3) begin
            failures++;
            $display("FAIL reset_mid_reach: got %0d compute entries required 3",
                     ce_cyc.size() - cb);
        end
        #1 reset = 1'b0;
        #1 check_all_zero("reset_mid");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_held");
        reset = 1'b1;
        yb = got_y.size();
        cb = ce_cyc.size();
        load_vec(X1, F1, 1'b0, 1'b1, 1'b1);
        collect(NY, 0);
        check_vec("reset_reload", X1, F1, yb, cb, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gaps();
        test_stall();
        test_extra_x();
        test_random();
        test_reset_mid();
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL protocol: got %0d violations required 0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
